// File: rtl/pipeline_ctrl.sv
// Pipeline enable/flush controller: turns hazard-unit and cache events into per-latch
// capture and bubble controls, and keeps the memory-wait watchdog, sticky halt and perf counters.
module pipeline_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             EXMEM_dREN,
    input  logic             EXMEM_dWEN,
    input  logic [1:0]       StallLW,
    input  logic             EXMEM_branch,
    input  logic             IFID_jump,
    input  logic             MEMWB_halt,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             MEMWB_flush,
    output logic             halt,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrlState_t;

    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] TIMEOUT_C  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

    ctrlState_t        state_r;
    ctrlState_t        stateNext_s;
    logic              memWait_s;
    logic              pcEn_s, ifidEn_s, idexEn_s, exmemEn_s, memwbEn_s;
    logic              ifidFlush_s, idexFlush_s, exmemFlush_s, memwbFlush_s;
    logic              stallInc_s, flushInc_s;
    logic              halt_r, memTimeout_r;
    logic [WAIT_W-1:0] waitCnt_r;
    logic [CNT_W-1:0]  stallCnt_r, flushCnt_r;

    assign memWait_s = (EXMEM_dREN | EXMEM_dWEN) & ~dhit;

    // Priority decode of this cycle's pipeline action and next controller state.
    always_comb begin
        pcEn_s       = 1'b0;
        ifidEn_s     = 1'b0;
        idexEn_s     = 1'b0;
        exmemEn_s    = 1'b0;
        memwbEn_s    = 1'b0;
        ifidFlush_s  = 1'b0;
        idexFlush_s  = 1'b0;
        exmemFlush_s = 1'b0;
        memwbFlush_s = 1'b0;
        stallInc_s   = 1'b0;
        flushInc_s   = 1'b0;
        stateNext_s  = state_r;
        if (RST) begin
            stateNext_s = RUN;
        end else begin
            case (state_r)
                RUN, DWAIT: begin
                    if (MEMWB_halt) begin
                        stateNext_s = HALTED;
                    end else if (memWait_s) begin
                        // Freeze everything upstream; MEM/WB drains into a bubble.
                        memwbEn_s    = 1'b1;
                        memwbFlush_s = 1'b1;
                        stallInc_s   = 1'b1;
                        stateNext_s  = DWAIT;
                    end else begin
                        stateNext_s = RUN;
                        if (EXMEM_branch) begin
                            pcEn_s       = 1'b1;
                            ifidEn_s     = 1'b1;
                            idexEn_s     = 1'b1;
                            exmemEn_s    = 1'b1;
                            memwbEn_s    = 1'b1;
                            ifidFlush_s  = 1'b1;
                            idexFlush_s  = 1'b1;
                            exmemFlush_s = 1'b1;
                            flushInc_s   = 1'b1;
                        end else if (StallLW != 2'b00) begin
                            idexEn_s    = 1'b1;
                            exmemEn_s   = 1'b1;
                            memwbEn_s   = 1'b1;
                            idexFlush_s = 1'b1;
                            stallInc_s  = 1'b1;
                        end else if (IFID_jump) begin
                            pcEn_s      = 1'b1;
                            ifidEn_s    = 1'b1;
                            idexEn_s    = 1'b1;
                            exmemEn_s   = 1'b1;
                            memwbEn_s   = 1'b1;
                            ifidFlush_s = 1'b1;
                            flushInc_s  = 1'b1;
                        end else if (!ihit) begin
                            ifidEn_s    = 1'b1;
                            idexEn_s    = 1'b1;
                            exmemEn_s   = 1'b1;
                            memwbEn_s   = 1'b1;
                            ifidFlush_s = 1'b1;
                            stallInc_s  = 1'b1;
                        end else begin
                            pcEn_s    = 1'b1;
                            ifidEn_s  = 1'b1;
                            idexEn_s  = 1'b1;
                            exmemEn_s = 1'b1;
                            memwbEn_s = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    stateNext_s = HALTED;
                end
                default: begin
                    stateNext_s = RUN;
                end
            endcase
        end
    end

    // Controller state, sticky flags, watchdog and performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= RUN;
            halt_r       <= 1'b0;
            memTimeout_r <= 1'b0;
            waitCnt_r    <= '0;
            stallCnt_r   <= '0;
            flushCnt_r   <= '0;
        end else begin
            state_r <= stateNext_s;
            halt_r  <= (stateNext_s == HALTED);
            if (stallInc_s) begin
                stallCnt_r <= stallCnt_r + CNT_W'(1);
            end
            if (flushInc_s) begin
                flushCnt_r <= flushCnt_r + CNT_W'(1);
            end
            // Only wait cycles spent already inside DWAIT count toward the watchdog.
            if ((state_r == DWAIT) && (stateNext_s == DWAIT)) begin
                if (waitCnt_r >= TIMEOUT_M1) begin
                    waitCnt_r    <= TIMEOUT_C;
                    memTimeout_r <= 1'b1;
                end else begin
                    waitCnt_r <= waitCnt_r + WAIT_W'(1);
                end
            end else begin
                waitCnt_r <= '0;
            end
        end
    end

    assign PC_en       = pcEn_s;
    assign IFID_en     = ifidEn_s;
    assign IDEX_en     = idexEn_s;
    assign EXMEM_en    = exmemEn_s;
    assign MEMWB_en    = memwbEn_s;
    assign IFID_flush  = ifidFlush_s;
    assign IDEX_flush  = idexFlush_s;
    assign EXMEM_flush = exmemFlush_s;
    assign MEMWB_flush = memwbFlush_s;
    assign halt        = halt_r;
    assign state       = state_r;
    assign mem_timeout = memTimeout_r;
    assign stall_cnt   = stallCnt_r;
    assign flush_cnt   = flushCnt_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table plus randomized traffic checked
// against a behavioural action-classification model.
module tb_pipeline_ctrl;
    localparam int CNT_W = 8;
    localparam int TO    = 4;

    // input vector bits: [9]RST [8]ihit [7]dhit [6]dREN [5]dWEN [4:3]StallLW [2]branch [1]jump [0]halt
    localparam logic [9:0] I_NONE = 10'h000;
    localparam logic [9:0] I_RST  = 10'h200;
    localparam logic [9:0] I_IHIT = 10'h100;
    localparam logic [9:0] I_DHIT = 10'h080;
    localparam logic [9:0] I_REN  = 10'h040;
    localparam logic [9:0] I_WEN  = 10'h020;
    localparam logic [9:0] I_SLW1 = 10'h008;
    localparam logic [9:0] I_BR   = 10'h004;
    localparam logic [9:0] I_JMP  = 10'h002;
    localparam logic [9:0] I_MH   = 10'h001;

    // output vector: {PC,IFID,IDEX,EXMEM,MEMWB en, IFID,IDEX,EXMEM,MEMWB flush}
    localparam logic [8:0] O_Z  = 9'b00000_0000;
    localparam logic [8:0] O_N  = 9'b11111_0000;
    localparam logic [8:0] O_MW = 9'b00001_0001;
    localparam logic [8:0] O_BR = 9'b11111_1110;
    localparam logic [8:0] O_SL = 9'b00111_0100;
    localparam logic [8:0] O_JP = 9'b11111_1000;
    localparam logic [8:0] O_NI = 9'b01111_1000;

    localparam int A_ZERO = 0, A_HALT = 1, A_WAIT = 2, A_BR = 3, A_SL = 4, A_JP = 5, A_NI = 6, A_N = 7;

    logic CLK;
    logic RST, ihit, dhit, EXMEM_dREN, EXMEM_dWEN, EXMEM_branch, IFID_jump, MEMWB_halt;
    logic [1:0] StallLW;
    logic PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush;
    logic halt, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .EXMEM_dREN(EXMEM_dREN), .EXMEM_dWEN(EXMEM_dWEN), .StallLW(StallLW),
        .EXMEM_branch(EXMEM_branch), .IFID_jump(IFID_jump), .MEMWB_halt(MEMWB_halt),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush), .MEMWB_flush(MEMWB_flush),
        .halt(halt), .state(state), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] in;
        logic [8:0] expOut;
        logic [1:0] expState;
        logic       expHalt;
        logic       expTo;
        int         expStall;
        int         expFlush;
    } vec_t;

    vec_t vecs[$];
    int nChecks = 0;
    int nFails  = 0;

    // reference model: mode 0 running, 1 waiting on data memory, 2 halted
    int mMode = 0, mHalt = 0, mTo = 0, mWait = 0, mStall = 0, mFlush = 0;
    int curAct;

    task automatic addVec(input logic [9:0] in, input logic [8:0] o, input logic [1:0] st,
                          input logic h, input logic to, input int stl, input int fl);
        vec_t v;
        v.in = in; v.expOut = o; v.expState = st; v.expHalt = h; v.expTo = to;
        v.expStall = stl; v.expFlush = fl;
        vecs.push_back(v);
    endtask

    task automatic applyInputs(input logic [9:0] v);
        RST = v[9]; ihit = v[8]; dhit = v[7]; EXMEM_dREN = v[6]; EXMEM_dWEN = v[5];
        StallLW = v[4:3]; EXMEM_branch = v[2]; IFID_jump = v[1]; MEMWB_halt = v[0];
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int classify();
        if (RST) return A_ZERO;
        if (mMode == 2) return A_ZERO;
        if (MEMWB_halt) return A_HALT;
        if ((EXMEM_dREN || EXMEM_dWEN) && !dhit) return A_WAIT;
        if (EXMEM_branch) return A_BR;
        if (StallLW != 2'b00) return A_SL;
        if (IFID_jump) return A_JP;
        if (!ihit) return A_NI;
        return A_N;
    endfunction

    function automatic logic [8:0] pattern(input int a);
        case (a)
            A_WAIT:  return O_MW;
            A_BR:    return O_BR;
            A_SL:    return O_SL;
            A_JP:    return O_JP;
            A_NI:    return O_NI;
            A_N:     return O_N;
            default: return O_Z;
        endcase
    endfunction

    // flush only matters where the latch is enabled; a fully idle cycle requires all flush low
    function automatic logic [3:0] flushMask(input logic [8:0] o);
        return (o[8:4] == 5'b00000) ? 4'hf : o[7:4];
    endfunction

    function automatic logic [8:0] gotOut();
        return {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
                IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_flush};
    endfunction

    task automatic checkModel();
        logic [8:0] exp;
        logic [8:0] got;
        logic [3:0] m;
        curAct = classify();
        exp = pattern(curAct);
        got = gotOut();
        m = flushMask(exp);
        cmp("model_en", 32'(got[8:4]), 32'(exp[8:4]));
        cmp("model_flush", 32'(got[3:0] & m), 32'(exp[3:0] & m));
        cmp("model_state", 32'(state), 32'(mMode));
        cmp("model_halt", 32'(halt), 32'(mHalt));
        cmp("model_timeout", 32'(mem_timeout), 32'(mTo));
        cmp("model_stall_cnt", 32'(stall_cnt), 32'(mStall));
        cmp("model_flush_cnt", 32'(flush_cnt), 32'(mFlush));
    endtask

    task automatic checkVec(input vec_t v, input int idx);
        logic [8:0] got;
        logic [3:0] m;
        got = gotOut();
        m = flushMask(v.expOut);
        cmp($sformatf("vec%0d_en", idx), 32'(got[8:4]), 32'(v.expOut[8:4]));
        cmp($sformatf("vec%0d_flush", idx), 32'(got[3:0] & m), 32'(v.expOut[3:0] & m));
        cmp($sformatf("vec%0d_state", idx), 32'(state), 32'(v.expState));
        cmp($sformatf("vec%0d_halt", idx), 32'(halt), 32'(v.expHalt));
        cmp($sformatf("vec%0d_timeout", idx), 32'(mem_timeout), 32'(v.expTo));
        cmp($sformatf("vec%0d_stall_cnt", idx), 32'(stall_cnt), 32'(v.expStall));
        cmp($sformatf("vec%0d_flush_cnt", idx), 32'(flush_cnt), 32'(v.expFlush));
    endtask

    task automatic modelUpdate();
        if (RST) begin
            mMode = 0; mHalt = 0; mTo = 0; mWait = 0; mStall = 0; mFlush = 0;
        end else begin
            case (curAct)
                A_HALT: begin mMode = 2; mHalt = 1; mWait = 0; end
                A_WAIT: begin
                    mStall = (mStall + 1) % (1 << CNT_W);
                    if (mMode == 1) begin
                        mWait = (mWait + 1 > TO) ? TO : mWait + 1;
                        if (mWait == TO) mTo = 1;
                    end
                    mMode = 1;
                end
                A_BR, A_JP: begin mFlush = (mFlush + 1) % (1 << CNT_W); mMode = 0; mWait = 0; end
                A_SL, A_NI: begin mStall = (mStall + 1) % (1 << CNT_W); mMode = 0; mWait = 0; end
                A_N:        begin mMode = 0; mWait = 0; end
                default:    begin end
            endcase
        end
    endtask

    initial begin
        int pcts[3];
        logic [9:0] v;
        pcts = '{70, 25, 5};

        addVec(I_RST, O_Z, 2'd0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) addVec(I_IHIT, O_N, 2'd0, 1'b0, 1'b0, 0, 0);
        addVec(I_IHIT | I_REN, O_MW, 2'd0, 1'b0, 1'b0, 0, 0);
        addVec(I_IHIT | I_REN, O_MW, 2'd1, 1'b0, 1'b0, 1, 0);
        addVec(I_IHIT | I_REN, O_MW, 2'd1, 1'b0, 1'b0, 2, 0);
        addVec(I_IHIT | I_REN | I_DHIT, O_N, 2'd1, 1'b0, 1'b0, 3, 0);
        addVec(I_IHIT | I_SLW1 | I_JMP, O_SL, 2'd0, 1'b0, 1'b0, 3, 0);
        addVec(I_SLW1 | I_BR, O_BR, 2'd0, 1'b0, 1'b0, 4, 0);
        addVec(I_IHIT | I_JMP, O_JP, 2'd0, 1'b0, 1'b0, 4, 1);
        addVec(I_NONE, O_NI, 2'd0, 1'b0, 1'b0, 4, 2);
        addVec(I_IHIT, O_N, 2'd0, 1'b0, 1'b0, 5, 2);
        addVec(I_IHIT | I_MH, O_Z, 2'd0, 1'b0, 1'b0, 5, 2);
        addVec(I_REN, O_Z, 2'd2, 1'b1, 1'b0, 5, 2);
        addVec(I_BR, O_Z, 2'd2, 1'b1, 1'b0, 5, 2);
        addVec(I_RST, O_Z, 2'd2, 1'b1, 1'b0, 5, 2);
        addVec(I_IHIT, O_N, 2'd0, 1'b0, 1'b0, 0, 0);
        // watchdog: ten store-wait cycles with TIMEOUT=4
        for (int k = 0; k < 10; k++)
            addVec(I_IHIT | I_WEN, O_MW, (k == 0) ? 2'd0 : 2'd1, 1'b0, (k >= 5), k, 0);
        addVec(I_RST, O_Z, 2'd1, 1'b0, 1'b1, 10, 0);
        addVec(I_IHIT, O_N, 2'd0, 1'b0, 1'b0, 0, 0);

        applyInputs(I_RST);
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            applyInputs(vecs[i].in);
            @(negedge CLK);
            checkModel();
            checkVec(vecs[i], i);
            modelUpdate();
            @(posedge CLK);
            #1;
        end

        for (int i = 0; i < 3000; i++) begin
            v = '0;
            v[9]   = ($urandom_range(0, 39) == 0);
            v[8]   = ($urandom_range(0, 3) != 0);
            v[7]   = ($urandom_range(0, 99) < pcts[(i / 200) % 3]);
            v[6]   = ($urandom_range(0, 4) == 0);
            v[5]   = ($urandom_range(0, 4) == 0);
            v[4:3] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v[2]   = ($urandom_range(0, 7) == 0);
            v[1]   = ($urandom_range(0, 7) == 0);
            v[0]   = ($urandom_range(0, 59) == 0);
            applyInputs(v);
            @(negedge CLK);
            checkModel();
            modelUpdate();
            @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
